// File: rtl/conv_pe_shift_reg_pkg.sv
// Shared defaults and geometry helper for the streaming 3x3 convolution PE.
package conv_pe_shift_reg_pkg;
  localparam int DEF_WIDTH = 9;
  localparam int DEF_IMG_W = 32;
  localparam int DEF_K     = 3;

  // Shift register length covering two full rows plus one kernel row.
  function automatic int line_len(input int k, input int img_w);
    return (k - 1) * img_w + k;
  endfunction
endpackage

// File: rtl/conv_pe_shift_reg_line_buffer_sr.sv
// Line-buffer shift register; exposes the KxK window taps, row-major (tap 0 = top-left).
module line_buffer_sr
  import conv_pe_shift_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IMG_W = DEF_IMG_W,
  parameter int K     = DEF_K
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [WIDTH-1:0]               data_i,
  output logic [K*K-1:0][WIDTH-1:0]      taps_o
);
  localparam int L = line_len(K, IMG_W);

  logic [L-1:0][WIDTH-1:0] sr_q, sr_d;

  always_comb sr_d = {sr_q[L-2:0], data_i};

  always_ff @(posedge clk) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  // Oldest pixel sits at the highest index, so the top-left tap is sr[L-1].
  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign taps_o[r*K+c] = sr_q[(K-1-r)*IMG_W + (K-1-c)];
    end
  end
endmodule

// File: rtl/conv_pe_shift_reg.sv
// Streaming 3x3 conv PE: kernel load on first 9 edges, then one signed MAC result per edge.
module conv_pe_shift_reg
  import conv_pe_shift_reg_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IMG_W = DEF_IMG_W,
  parameter int K     = DEF_K
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_in,
  input  logic [WIDTH-1:0]     weight_in,
  output logic [2*WIDTH-1:0]   data_out
);
  localparam int L   = line_len(K, IMG_W);
  localparam int NT  = K * K;
  localparam int PW  = 2 * WIDTH;
  localparam int AW  = PW + 4;
  localparam int CW  = $clog2(L + 1);
  localparam int WCW = $clog2(NT + 1);

  logic [CW-1:0]              pcnt_q, pcnt_d;
  logic [WCW-1:0]             wcnt_q, wcnt_d;
  logic [NT-1:0][WIDTH-1:0]   w_q, w_d;
  logic [NT-1:0][WIDTH-1:0]   taps;
  logic [PW-1:0]              dout_q, dout_d;
  logic signed [PW-1:0]       prod [NT];
  logic signed [AW-1:0]       acc;

  line_buffer_sr #(
    .WIDTH(WIDTH),
    .IMG_W(IMG_W),
    .K    (K)
  ) u_lb (
    .clk   (clk),
    .rst_n (rst_n),
    .data_i(data_in),
    .taps_o(taps)
  );

  // Operands are sign-extended to full product width before multiplying.
  for (genvar i = 0; i < NT; i++) begin : g_mul
    assign prod[i] = PW'(signed'(taps[i])) * PW'(signed'(w_q[i]));
  end

  always_comb begin
    acc = '0;
    for (int i = 0; i < NT; i++) acc = acc + AW'(prod[i]);
  end

  always_comb begin
    w_d    = w_q;
    wcnt_d = wcnt_q;
    if (wcnt_q < WCW'(NT)) begin
      w_d[wcnt_q] = weight_in;
      wcnt_d      = wcnt_q + WCW'(1);
    end
    pcnt_d = (pcnt_q < CW'(L)) ? pcnt_q + CW'(1) : pcnt_q;
    // Sum wraps to the output width; no saturation.
    dout_d = (pcnt_q < CW'(L)) ? '0 : acc[PW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt_q <= '0;
      wcnt_q <= '0;
      w_q    <= '0;
      dout_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      wcnt_q <= wcnt_d;
      w_q    <= w_d;
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;
endmodule

// File: tb/tb_conv_pe_shift_reg.sv
// Self-checking bench for conv_pe_shift_reg against a pixel-history reference model.
module tb_conv_pe_shift_reg;
  localparam int IW = 32;
  localparam int LL = 67;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  data_in;
  logic [8:0]  weight_in;
  logic [17:0] data_out;

  int checks = 0;
  int errors = 0;

  // model state: captured pixels (newest first), kernel, edges since reset
  int hist[$];
  int wm[9];
  int n;

  conv_pe_shift_reg dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_in  (data_in),
    .weight_in(weight_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  function automatic int sx(input logic [8:0] v);
    return int'($signed(v));
  endfunction

  // 3x3 dot product of the kernel with the window ending at the newest pixel.
  function automatic logic [17:0] model_out();
    int s;
    if (n < LL) return 18'd0;
    s = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        s += wm[r*3+c] * hist[(2-r)*IW + (2-c)];
    return 18'(s);
  endfunction

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [8:0] px, input logic [8:0] wt, input logic rn, input string tag);
    logic [17:0] e;
    data_in   = px;
    weight_in = wt;
    rst_n     = rn;
    e = rn ? model_out() : 18'd0;
    @(posedge clk);
    #1;
    if (!rn) begin
      hist.delete();
      for (int i = 0; i < 9; i++) wm[i] = 0;
      n = 0;
    end else begin
      if (n < 9) wm[n] = sx(wt);
      hist.push_front(sx(px));
      if (hist.size() > LL) void'(hist.pop_back());
      n++;
    end
    chk(tag, data_out, e);
  endtask

  initial begin
    int kw[9];
    n = 0;
    data_in = '0; weight_in = '0; rst_n = 1'b0;
    step(9'd0, 9'd0, 1'b0, "reset0");
    step(9'd0, 9'd0, 1'b0, "reset1");

    // weights 1..9, flat image of ones
    for (int i = 0; i < 80; i++) begin
      step(9'd1, (i < 9) ? 9'(i + 1) : 9'd0, 1'b1, "t1");
      if (n == 67) chk("t1_e67", data_out, 18'd0);
      if (n == 68) chk("t1_e68", data_out, 18'd45);
    end

    // all-ones kernel, pixels 2; later weight_in changes must be ignored
    step(9'd0, 9'd0, 1'b0, "t2_rst");
    for (int i = 0; i < 80; i++) step(9'd2, (i < 9) ? 9'd1 : 9'd7, 1'b1, "t2");
    chk("t2_ss", data_out, 18'd18);

    // negative kernel
    step(9'd0, 9'd0, 1'b0, "t3_rst");
    for (int i = 0; i < 70; i++) step(9'd3, 9'h1FF, 1'b1, "t3");
    chk("t3_neg", data_out, 18'h3FFE5);

    // fixed kernel, random signed pixels, reset at edge 80
    kw = '{1, 2, 3, 2, 3, 4, 3, 4, 5};
    step(9'd0, 9'd0, 1'b0, "t4_rst");
    for (int i = 0; i < 79; i++)
      step(9'($urandom_range(0, 511)), (i < 9) ? 9'(kw[i]) : 9'($urandom_range(0, 511)), 1'b1, "t4");
    step(9'($urandom_range(0, 511)), 9'd0, 1'b0, "t4_midrst");
    chk("t4_rst_zero", data_out, 18'd0);
    // reload a random kernel after release
    for (int i = 0; i < 90; i++) begin
      step(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 1'b1, "t4b");
      if (n == 67) chk("t4b_e67", data_out, 18'd0);
    end

    // max positive operands: wrap to 18 bits
    step(9'd0, 9'd0, 1'b0, "t5_rst");
    for (int i = 0; i < 70; i++) step(9'd255, 9'd255, 1'b1, "t5");
    chk("t5_wrap", data_out, 18'd60937);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
